// File: rtl/ysyx_22050854_imem_responder.sv
// ============================================================================
// Module   : ysyx_22050854_imem_responder
// Brief    : Instruction-memory responder for the ysyx_22050854 fetch path.
//            Accepts one PC at a time over a valid/ready request channel and
//            returns the 32-bit word LATENCY cycles after the handshake over
//            a valid/ready response channel. A word-addressed store is
//            preloaded through the ld_* port.
// Options  : YSYX_22050854_IMEM_EBREAK_TRAP_EN - latch trap_hit when an
//            ebreak word is fetched and block further requests until rst.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_22050854_imem_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          DEPTH     = 1024,
  parameter int          LATENCY   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [31:0]              req_addr,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [31:0]              rsp_inst,
  output logic                     rsp_err,
  input  logic                     ld_en,
  input  logic [$clog2(DEPTH)-1:0] ld_idx,
  input  logic [31:0]              ld_data,
  output logic                     trap_hit
);

  localparam int                IDX_W    = $clog2(DEPTH);
  localparam int                CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(LATENCY - 1);
  localparam logic [31:0]       C_EBREAK = 32'h0010_0073;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      rsp_inst_q, rsp_inst_d;
  logic             rsp_err_q, rsp_err_d;
  logic             trap_q, trap_d;

  logic [31:0]      mem [DEPTH];

  // Address decode of the latched PC; evaluated on the edge that enters RESP.
  logic [31:0]      offset;
  logic             fault;
  logic [31:0]      word;
  logic             unused_offset_lsbs;

  assign offset             = addr_q - BASE_ADDR;
  assign fault              = (addr_q[1:0] != 2'b00) ||
                              (addr_q < BASE_ADDR) ||
                              ({2'b00, offset[31:2]} >= 32'(DEPTH));
  assign word               = mem[offset[IDX_W+1:2]];
  assign unused_offset_lsbs = ^offset[1:0];

  assign req_ready = (state_q == IDLE) && !trap_q;
  assign rsp_valid = (state_q == RESP);
  assign rsp_inst  = rsp_inst_q;
  assign rsp_err   = rsp_err_q;
  assign trap_hit  = trap_q;

  // Next-state and response capture. The counter is loaded with LATENCY-1 at
  // the handshake and WAIT exits once it has run down to zero, so LATENCY==1
  // spends a single cycle in WAIT and rsp_valid rises LATENCY edges later.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    rsp_inst_d = rsp_inst_q;
    rsp_err_d  = rsp_err_q;
    trap_d     = trap_q;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          addr_d  = req_addr;
          cnt_d   = CNT_LOAD;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d    = RESP;
          rsp_inst_d = fault ? 32'h0 : word;
          rsp_err_d  = fault;
`ifdef YSYX_22050854_IMEM_EBREAK_TRAP_EN
          if (!fault && (word == C_EBREAK)) begin
            trap_d = 1'b1;
          end
`endif
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
`ifndef YSYX_22050854_IMEM_EBREAK_TRAP_EN
    trap_d = 1'b0;
`endif
  end

  // Control and response registers; reset drops any in-flight request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= 32'h0;
      rsp_inst_q <= 32'h0;
      rsp_err_q  <= 1'b0;
      trap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      rsp_inst_q <= rsp_inst_d;
      rsp_err_q  <= rsp_err_d;
      trap_q     <= trap_d;
    end
  end

  // Backing store write port; not reset, and a write on the sampling edge is
  // not seen by that response because the read above uses the old contents.
  always_ff @(posedge clk) begin
    if (ld_en) begin
      mem[ld_idx] <= ld_data;
    end
  end

endmodule

`default_nettype wire
